// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Control bundle between the multicycle controller (master)
//               and the 16-bit accumulator datapath (slave).
//               Datapath -> controller : opcode (IR[15:12]), zero (ALU flag)
//               Controller -> datapath : PC/IR/memory/ACC enables, mux
//                                        selects, ALU op code, halted
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
    logic [3:0] opcode;
    logic       zero;
    logic       pcLd;
    logic       pcSrc;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       accWrite;
    logic       accSrc;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       halted;

    modport master (
        input  opcode, zero,
        output pcLd, pcSrc, irWrite, memRead, memWrite, iOrD,
               accWrite, accSrc, aluSrcA, aluSrcB, aluOp, halted
    );

    modport slave (
        output opcode, zero,
        input  pcLd, pcSrc, irWrite, memRead, memWrite, iOrD,
               accWrite, accSrc, aluSrcA, aluSrcB, aluOp, halted
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Fetch/decode/execute control FSM for the 16-bit accumulator
//               multicycle datapath. Moore outputs decoded from state, except
//               pcLd in BRZ which follows the ALU zero flag combinationally.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-low reset (returns to IDLE)
//               bus  - master side of multicycle_controller_if
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  wire logic              clk,
    input  wire logic              rst,
    multicycle_controller_if.master bus
);

    localparam logic [3:0] c_OP_LOAD  = 4'b0000;
    localparam logic [3:0] c_OP_STORE = 4'b0001;
    localparam logic [3:0] c_OP_JMP   = 4'b0010;
    localparam logic [3:0] c_OP_BRZ   = 4'b0011;
    localparam logic [3:0] c_OP_ADD   = 4'b1000;
    localparam logic [3:0] c_OP_SUB   = 4'b1001;
    localparam logic [3:0] c_OP_AND   = 4'b1010;
    localparam logic [3:0] c_OP_NOT   = 4'b1011;
    localparam logic [3:0] c_OP_HALT  = 4'b1111;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_NOTB = 3'b011;
    localparam logic [2:0] c_ALU_ZT   = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMRD  = 4'd3,
        S_LDWB   = 4'd4,
        S_ALU    = 4'd5,
        S_MEMWR  = 4'd6,
        S_JMP    = 4'd7,
        S_BRZ    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t r_state;
    state_t w_next;

    // State register: reset aborts any instruction in flight; because every
    // output is decoded from r_state, enables drop as soon as rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // Unused encodings fall through to FETCH with all outputs low.
        w_next       = S_FETCH;
        bus.pcLd     = 1'b0;
        bus.pcSrc    = 1'b0;
        bus.irWrite  = 1'b0;
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.iOrD     = 1'b0;
        bus.accWrite = 1'b0;
        bus.accSrc   = 1'b0;
        bus.aluSrcA  = 1'b0;
        bus.aluSrcB  = 2'b00;
        bus.aluOp    = c_ALU_ADD;
        bus.halted   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                // IR <= mem[PC] while the ALU computes PC+1 into the PC.
                bus.memRead = 1'b1;
                bus.irWrite = 1'b1;
                bus.aluSrcB = 2'b01;
                bus.aluOp   = c_ALU_ADD;
                bus.pcLd    = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_LOAD, c_OP_ADD,
                    c_OP_SUB, c_OP_AND:  w_next = S_MEMRD;
                    c_OP_STORE:          w_next = S_MEMWR;
                    c_OP_JMP:            w_next = S_JMP;
                    c_OP_BRZ:            w_next = S_BRZ;
                    c_OP_NOT:            w_next = S_ALU;
                    c_OP_HALT:           w_next = S_HALT;
                    default:             w_next = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                bus.memRead = 1'b1;
                bus.iOrD    = 1'b1;
                w_next      = (bus.opcode == c_OP_LOAD) ? S_LDWB : S_ALU;
            end
            S_LDWB: begin
                bus.accWrite = 1'b1;
                bus.accSrc   = 1'b1;
                w_next       = S_FETCH;
            end
            S_ALU: begin
                bus.aluSrcA  = 1'b1;
                bus.accWrite = 1'b1;
                case (bus.opcode)
                    c_OP_SUB: bus.aluOp = c_ALU_SUB;
                    c_OP_AND: bus.aluOp = c_ALU_AND;
                    c_OP_NOT: begin
                        bus.aluOp   = c_ALU_NOTB;
                        bus.aluSrcB = 2'b10;
                    end
                    default:  bus.aluOp = c_ALU_ADD;
                endcase
                w_next = S_FETCH;
            end
            S_MEMWR: begin
                bus.memWrite = 1'b1;
                bus.iOrD     = 1'b1;
                w_next       = S_FETCH;
            end
            S_JMP: begin
                bus.pcLd  = 1'b1;
                bus.pcSrc = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRZ: begin
                // Zero-test of ACC; the branch is taken in this same cycle.
                bus.aluSrcA = 1'b1;
                bus.aluOp   = c_ALU_ZT;
                bus.pcSrc   = 1'b1;
                bus.pcLd    = bus.zero;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                w_next     = S_HALT;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. A per-
//               instruction model expands each opcode into its expected
//               cycle-by-cycle control vectors; a negedge compare process
//               checks the DUT against them. Random instruction streams plus
//               directed reset, abort and halt scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic clk;
    logic rst;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Packed view of all outputs:
    // {pcLd,pcSrc,irWrite,memRead,memWrite,iOrD,accWrite,accSrc,aluSrcA,aluSrcB,aluOp,halted}
    logic [14:0] w_vec;
    assign w_vec = {bus.pcLd, bus.pcSrc, bus.irWrite, bus.memRead, bus.memWrite,
                    bus.iOrD, bus.accWrite, bus.accSrc, bus.aluSrcA, bus.aluSrcB,
                    bus.aluOp, bus.halted};

    logic [14:0] exp_vec;
    logic        chk_en;
    logic [14:0] exp_q[$];

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Build one output vector from named fields.
    function automatic logic [14:0] pack(
        input logic pl, input logic ps, input logic irw, input logic mr,
        input logic mw, input logic iod, input logic aw, input logic as,
        input logic asa, input logic [1:0] asb, input logic [2:0] op, input logic h);
        return {pl, ps, irw, mr, mw, iod, aw, as, asa, asb, op, h};
    endfunction

    // Expected per-cycle outputs for one instruction, FETCH through last step.
    task automatic build(input logic [3:0] op, input logic zb);
        logic [14:0] fetch_v, memrd_v;
        fetch_v = pack(1,0,1,1,0,0,0,0,0,2'b01,3'b000,0);
        memrd_v = pack(0,0,0,1,0,1,0,0,0,2'b00,3'b000,0);
        exp_q.delete();
        exp_q.push_back(fetch_v);
        exp_q.push_back(15'h0);
        case (op)
            4'b0000: begin exp_q.push_back(memrd_v); exp_q.push_back(pack(0,0,0,0,0,0,1,1,0,2'b00,3'b000,0)); end
            4'b1000: begin exp_q.push_back(memrd_v); exp_q.push_back(pack(0,0,0,0,0,0,1,0,1,2'b00,3'b000,0)); end
            4'b1001: begin exp_q.push_back(memrd_v); exp_q.push_back(pack(0,0,0,0,0,0,1,0,1,2'b00,3'b001,0)); end
            4'b1010: begin exp_q.push_back(memrd_v); exp_q.push_back(pack(0,0,0,0,0,0,1,0,1,2'b00,3'b010,0)); end
            4'b1011: exp_q.push_back(pack(0,0,0,0,0,0,1,0,1,2'b10,3'b011,0));
            4'b0001: exp_q.push_back(pack(0,0,0,0,1,1,0,0,0,2'b00,3'b000,0));
            4'b0010: exp_q.push_back(pack(1,1,0,0,0,0,0,0,0,2'b00,3'b000,0));
            4'b0011: exp_q.push_back(pack(zb,1,0,0,0,0,0,0,1,2'b00,3'b100,0));
            4'b1111: for (int k = 0; k < 20; k++) exp_q.push_back(pack(0,0,0,0,0,0,0,0,0,2'b00,3'b000,1));
            default: ;
        endcase
    endtask

    // Drives one instruction; zero is random except in the BRZ cycle.
    task automatic run_instr(input logic [3:0] op, input logic zb);
        int n;
        build(op, zb);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.opcode = op;
            bus.zero   = (op == 4'b0011 && i == 2) ? zb : 1'($urandom_range(0, 1));
            exp_vec    = exp_q[i];
            chk_en     = 1'b1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        exp_vec = 15'h0;
        chk_en  = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_vec", w_vec, exp_vec);
            if (bus.memRead && bus.memWrite)
                check("rd_wr_exclusive", {13'h0, bus.memRead, bus.memWrite}, 15'h0);
        end
    end

    initial begin
        logic [3:0] op;
        rst        = 1'b0;
        chk_en     = 1'b0;
        exp_vec    = 15'h0;
        bus.opcode = 4'h0;
        bus.zero   = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("reset_outputs", w_vec, 15'h0);
        release_reset();

        // First instruction after reset, with literal pins on each step.
        fork
            run_instr(4'b1000, 1'b0);
            begin
                @(posedge clk); #2 check("lit_fetch", w_vec, 15'h5810);
                @(posedge clk); #2 check("lit_decode", w_vec, 15'h0000);
                @(posedge clk); #2 check("lit_memrd", w_vec, 15'h0A00);
                @(posedge clk); #2 check("lit_alu_add", w_vec, 15'h0140);
            end
        join
        run_instr(4'b1001, 1'b0);
        run_instr(4'b1010, 1'b0);
        fork
            run_instr(4'b1011, 1'b0);
            begin
                @(posedge clk); @(posedge clk); @(posedge clk);
                #2 check("lit_alu_not", w_vec, 15'h0166);
            end
        join
        fork
            run_instr(4'b0011, 1'b1);
            begin
                @(posedge clk); @(posedge clk); @(posedge clk);
                #2 check("lit_brz_taken", w_vec, 15'h6048);
            end
        join
        run_instr(4'b0011, 1'b0);
        run_instr(4'b0000, 1'b0);
        run_instr(4'b0001, 1'b0);
        run_instr(4'b0010, 1'b0);
        run_instr(4'b0101, 1'b0);

        // Random instruction stream (HALT excluded; it is tested last).
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b1111) op = 4'b0101;
            run_instr(op, 1'($urandom_range(0, 1)));
        end

        // Reset asserted mid-cycle during MEMWR must drop memWrite at once.
        @(posedge clk); #1 bus.opcode = 4'b0001; chk_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("lit_memwr", w_vec, 15'h0600);
        #2 rst = 1'b0;
        #1 check("abort_memwr", w_vec, 15'h0);
        repeat (2) @(posedge clk);
        release_reset();
        run_instr(4'b0101, 1'b0);
        run_instr(4'b0000, 1'b0);

        // HALT holds for 20 cycles, then async reset clears it before an edge.
        run_instr(4'b1111, 1'b0);
        @(posedge clk);
        #1 check("halt_hold", w_vec, 15'h0001);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1 check("halt_async_clear", w_vec, 15'h0);
        repeat (2) @(posedge clk);
        release_reset();
        run_instr(4'b0010, 1'b0);
        @(posedge clk);
        #1 chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
